// File: rtl/mem_ctrl_if.sv
// Request/done handshake between the control unit (master) and mem_ctrl (slave).
interface mem_ctrl_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              rd_req;
  logic              wr_req;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output rd_req, wr_req, addr, wdata,
    input  rdata, busy, done, err
  );

  modport slave (
    input  rd_req, wr_req, addr, wdata,
    output rdata, busy, done, err
  );
endinterface

// File: rtl/mem_ctrl.sv
// Word-addressed RAM behind a request/done handshake with LAT fixed wait states.
// Optional write protection of addresses below ROM_TOP: define MEM_WRITE_PROTECT_EN.
module mem_ctrl #(
  parameter int                ADDR_W  = 9,
  parameter int                DATA_W  = 32,
  parameter int                DEPTH   = 512,
  parameter int                LAT     = 2,
  parameter logic [ADDR_W-1:0] ROM_TOP = 9'h040
) (
  input  logic     clk,
  input  logic     clr,
  mem_ctrl_if.slave bus
);

  localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]  r_addr;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_rdata;
  logic              r_busy, r_done, r_err;
  logic              w_busy_nxt, w_done_nxt, w_err_nxt;
  logic              w_accept, w_accept_wr, w_rd_cpl, w_wr_cpl;
  logic              w_in_range, w_prot_hit, w_mem_we;
  logic [DATA_W-1:0] r_mem [DEPTH];

  if (LAT < 1 || LAT > 15) begin : g_bad_lat
    $error("mem_ctrl: LAT must be within 1..15");
  end
  if (DEPTH > 2**ADDR_W || 32'(ROM_TOP) > DEPTH) begin : g_bad_depth
    $error("mem_ctrl: DEPTH exceeds address space or ROM_TOP exceeds DEPTH");
  end

  if (DEPTH >= 2**ADDR_W) begin : g_full_range
    assign w_in_range = 1'b1;
  end else begin : g_part_range
    assign w_in_range = (32'(bus.addr) < DEPTH);
  end

`ifdef MEM_WRITE_PROTECT_EN
  logic r_prot;

  // Protection decision is taken on the address as accepted, not as it drifts while busy.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_prot <= 1'b0;
    end else if (w_accept_wr) begin
      r_prot <= (bus.addr < ROM_TOP);
    end else begin
      r_prot <= r_prot;
    end
  end
  assign w_prot_hit = r_prot;
`else
  assign w_prot_hit = 1'b0;
`endif

  assign w_mem_we = w_wr_cpl & ~w_prot_hit;

  // Next-state, counter and output-pulse decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_accept    = 1'b0;
    w_accept_wr = 1'b0;
    w_rd_cpl    = 1'b0;
    w_wr_cpl    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.rd_req && bus.wr_req) begin
          w_err_nxt = 1'b1;
        end else if ((bus.rd_req || bus.wr_req) && !w_in_range) begin
          w_err_nxt = 1'b1;
        end else if (bus.rd_req || bus.wr_req) begin
          w_accept    = 1'b1;
          w_accept_wr = bus.wr_req;
          w_state_nxt = bus.wr_req ? WR_WAIT : RD_WAIT;
          w_cnt_nxt   = CNT_INIT;
          w_busy_nxt  = 1'b1;
        end else begin
          w_busy_nxt = 1'b0;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_rd_cpl    = (r_state == RD_WAIT);
          w_wr_cpl    = (r_state == WR_WAIT);
          w_done_nxt  = ~(w_wr_cpl & w_prot_hit);
          w_err_nxt   = w_wr_cpl & w_prot_hit;
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Control state, latched request and registered outputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_data  <= '0;
      r_rdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_addr  <= w_accept    ? bus.addr[IDX_W-1:0] : r_addr;
      r_data  <= w_accept_wr ? bus.wdata           : r_data;
      r_rdata <= w_rd_cpl    ? r_mem[r_addr]       : r_rdata;
    end
  end

  // RAM array: contents deliberately survive clr.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_addr] <= r_data;
    end
  end

  assign bus.rdata = r_rdata;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.err   = r_err;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus randomized traffic vs. a transaction-level model.
module tb_mem_ctrl;
  localparam int         ADDR_W  = 9;
  localparam int         DATA_W  = 32;
  localparam int         DEPTH   = 256;
  localparam int         LAT     = 2;
  localparam logic [8:0] ROM_TOP = 9'h040;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  mem_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .LAT(LAT), .ROM_TOP(ROM_TOP)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding transaction completing LAT edges after acceptance.
  logic [31:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  bit          m_pend = 1'b0;
  bit          m_is_wr;
  int          m_cpl;
  int          m_addr;
  logic [31:0] m_data;
  int          cyc = 0;
  logic        e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;
  logic [31:0] e_rdata = 32'd0;
  bit          e_rd_known = 1'b1;

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_pend = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
      e_rdata = 32'd0; e_rd_known = 1'b1;
    end else begin
      cyc++;
      e_done = 1'b0;
      e_err  = 1'b0;
      if (m_pend) begin
        if (cyc == m_cpl) begin
          m_pend = 1'b0;
          e_busy = 1'b0;
          if (!m_is_wr) begin
            e_rdata = m_mem[m_addr]; e_rd_known = m_known[m_addr]; e_done = 1'b1;
`ifdef MEM_WRITE_PROTECT_EN
          end else if (m_addr < int'(ROM_TOP)) begin
            e_err = 1'b1;
`endif
          end else begin
            m_mem[m_addr] = m_data; m_known[m_addr] = 1'b1; e_done = 1'b1;
          end
        end
      end else if (bus.rd_req && bus.wr_req) begin
        e_err = 1'b1;
      end else if (bus.rd_req || bus.wr_req) begin
        if (int'(bus.addr) >= DEPTH) begin
          e_err = 1'b1;
        end else begin
          m_pend = 1'b1; m_is_wr = bus.wr_req; m_cpl = cyc + LAT;
          m_addr = int'(bus.addr); m_data = bus.wdata; e_busy = 1'b1;
        end
      end
    end
  end

  // Compare process: every cycle out of reset, DUT outputs against the model.
  always @(negedge clk) begin
    if (!clr) begin
      chk("busy", 32'(bus.busy), 32'(e_busy));
      chk("done", 32'(bus.done), 32'(e_done));
      chk("err",  32'(bus.err),  32'(e_err));
      if (e_rd_known) chk("rdata", bus.rdata, e_rdata);
      checks++;
      if (bus.done && bus.err) begin
        errors++;
        $display("FAIL done_err_overlap got=both_high exp=exclusive t=%0t", $time);
      end
    end
  end

  task automatic do_txn(input logic rd, input logic wr, input logic [8:0] a, input logic [31:0] d,
                        output int lat, output logic saw_done, output logic saw_err);
    bus.rd_req = rd; bus.wr_req = wr; bus.addr = a; bus.wdata = d;
    @(negedge clk);
    bus.rd_req = 1'b0; bus.wr_req = 1'b0;
    lat = 1;
    while (!bus.done && !bus.err && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    saw_done = bus.done;
    saw_err  = bus.err;
    if (lat >= 20) begin
      checks++; errors++;
      $display("FAIL txn_timeout got=%0d cycles exp=<20", lat);
    end
  endtask

  int   lat;
  logic sd, se;
  int   d1, d2;

  initial begin
    bus.rd_req = 1'b0; bus.wr_req = 1'b0; bus.addr = 9'd0; bus.wdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_done",  32'(bus.done), 32'd0);
    chk("rst_err",   32'(bus.err),  32'd0);
    chk("rst_rdata", bus.rdata,     32'd0);
    clr = 1'b0;
    @(negedge clk);

    // write then read
    do_txn(1'b0, 1'b1, 9'h0A0, 32'h1234_5678, lat, sd, se);
    chk("wr_lat", 32'(lat), 32'd3);
    chk("wr_done", 32'(sd), 32'd1);
    do_txn(1'b1, 1'b0, 9'h0A0, 32'h0, lat, sd, se);
    chk("rd_lat", 32'(lat), 32'd3);
    chk("rd_data", bus.rdata, 32'h1234_5678);
    repeat (2) @(negedge clk);
    chk("rd_hold", bus.rdata, 32'h1234_5678);

    // conflict
    do_txn(1'b1, 1'b1, 9'h0A0, 32'hFFFF_0000, lat, sd, se);
    chk("conf_err", 32'(se), 32'd1);
    chk("conf_lat", 32'(lat), 32'd1);
    @(negedge clk);
    chk("conf_err_one", 32'(bus.err), 32'd0);
    chk("conf_busy", 32'(bus.busy), 32'd0);

    // write pulsed while a read is busy is ignored
    bus.rd_req = 1'b1; bus.addr = 9'h0A0;
    @(negedge clk);
    bus.rd_req = 1'b0; bus.wr_req = 1'b1; bus.wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.wr_req = 1'b0;
    repeat (3) @(negedge clk);
    do_txn(1'b1, 1'b0, 9'h0A0, 32'h0, lat, sd, se);
    chk("ign_rd", bus.rdata, 32'h1234_5678);

    // clr one cycle after write acceptance
    bus.wr_req = 1'b1; bus.addr = 9'h0A0; bus.wdata = 32'hCAFE_0001;
    @(negedge clk);
    bus.wr_req = 1'b0;
    #1 clr = 1'b1;
    #1;
    chk("clr_busy",  32'(bus.busy), 32'd0);
    chk("clr_done",  32'(bus.done), 32'd0);
    chk("clr_rdata", bus.rdata,     32'd0);
    @(negedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    do_txn(1'b1, 1'b0, 9'h0A0, 32'h0, lat, sd, se);
    chk("clr_rd", bus.rdata, 32'h1234_5678);

    // out of range, then back-to-back reads
    do_txn(1'b1, 1'b0, 9'h1FF, 32'h0, lat, sd, se);
    chk("oor_err", 32'(se), 32'd1);
    chk("oor_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    d1 = -1; d2 = -1;
    bus.rd_req = 1'b1; bus.addr = 9'h0A0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.done && d1 < 0) d1 = k;
      else if (bus.done && d2 < 0) d2 = k;
    end
    bus.rd_req = 1'b0;
    chk("b2b_first", 32'(d1), 32'd3);
    chk("b2b_gap", 32'(d2 - d1), 32'd3);
    repeat (4) @(negedge clk);

`ifdef MEM_WRITE_PROTECT_EN
    do_txn(1'b0, 1'b1, 9'h010, 32'h0000_00FF, lat, sd, se);
    chk("wp_err", 32'(se), 32'd1);
    chk("wp_nodone", 32'(sd), 32'd0);
    chk("wp_lat", 32'(lat), 32'd3);
    do_txn(1'b0, 1'b1, 9'h040, 32'h0000_0040, lat, sd, se);
    chk("wp_edge_done", 32'(sd), 32'd1);
`else
    do_txn(1'b0, 1'b1, 9'h010, 32'h0000_00FF, lat, sd, se);
    chk("nowp_done", 32'(sd), 32'd1);
    do_txn(1'b1, 1'b0, 9'h010, 32'h0, lat, sd, se);
    chk("nowp_rd", bus.rdata, 32'h0000_00FF);
`endif
    @(negedge clk);

    // randomized traffic; the compare process checks every cycle
    for (int i = 0; i < 1500; i++) begin
      int r;
      @(negedge clk);
      r = $urandom_range(0, 99);
      if (r < 1) begin
        #1 clr = 1'b1;
        @(negedge clk);
        #1 clr = 1'b0;
      end else begin
        bus.rd_req = (r >= 5 && r < 45);
        bus.wr_req = (r >= 40 && r < 75);
        bus.addr   = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(256, 511))
                                                 : 9'($urandom_range(0, 47) + ((r & 1) ? 0 : 32));
        bus.wdata  = $urandom;
      end
    end
    bus.rd_req = 1'b0; bus.wr_req = 1'b0;
    repeat (6) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
